// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: word size, receiver states and
// the values the input synchronisers take on reset.
package spi_pkg;

  localparam int SPI_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

  // Reset presets look like an idle, deselected bus.
  localparam logic SYNC_RST_SCLK = 1'b0;
  localparam logic SYNC_RST_CS   = 1'b1;
  localparam logic SYNC_RST_MOSI = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings sclk/cs/mosi into the clk domain and flags sclk falling edges.
// The fall flag is built from registered samples only, so it is glitch-free.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= {SYNC_STAGES{SYNC_RST_SCLK}};
      r_cs_sync   <= {SYNC_STAGES{SYNC_RST_CS}};
      r_mosi_sync <= {SYNC_STAGES{SYNC_RST_MOSI}};
      r_sclk_prev <= SYNC_RST_SCLK;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign fall     = r_sclk_prev & ~w_sclk_s;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI receiver: deserialises LSB-first frames sampled on sclk falling edges
// into a one-entry valid/ready output with sticky overrun/framing flags.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_EDGES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             err_clr,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int BIT_CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LEAD_CNT_W = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES) : 1;
  localparam int SETTLE_W   = $clog2(SYNC_STAGES + 1);

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST   = BIT_CNT_W'(WIDTH - 1);
  localparam logic [LEAD_CNT_W-1:0] LEAD_LAST  = LEAD_CNT_W'((LEAD_EDGES > 0) ? LEAD_EDGES - 1 : 0);
  localparam logic [SETTLE_W-1:0]   SETTLE_MAX = SETTLE_W'(SYNC_STAGES);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic                  w_cs_s;
  logic                  w_mosi_s;
  logic                  w_fall;

  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [LEAD_CNT_W-1:0] r_lead_cnt;
  logic [WIDTH-1:0]      r_shift;
  logic [WIDTH-1:0]      w_shift_next;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_armed;

  logic [WIDTH-1:0]      r_dout;
  logic                  r_dout_valid;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic                  w_cnt_clr;
  logic                  w_lead_inc;
  logic                  w_shift_en;
  logic                  w_word_done;
  logic                  w_ferr_evt;
  logic                  w_accept;
  logic                  w_ovr_evt;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .cs_s   (w_cs_s),
    .mosi_s (w_mosi_s),
    .fall   (w_fall)
  );

  assign w_shift_next = {w_mosi_s, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_lead_inc  = 1'b0;
    w_shift_en  = 1'b0;
    w_word_done = 1'b0;
    w_ferr_evt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_cs_s) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = (LEAD_EDGES == 0) ? SHIFT : LEAD;
        end
      end
      LEAD: begin
        if (w_cs_s) begin
          w_ferr_evt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_fall) begin
          if (r_lead_cnt == LEAD_LAST) begin
            w_state_nxt = SHIFT;
          end else begin
            w_lead_inc = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A completing fall beats a simultaneous cs release.
        if (w_fall && (r_bit_cnt == BIT_LAST)) begin
          w_shift_en  = 1'b1;
          w_word_done = 1'b1;
          w_state_nxt = DONE;
        end else if (w_cs_s) begin
          w_ferr_evt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_fall) begin
          w_shift_en = 1'b1;
        end
      end
      DONE: begin
        if (w_cs_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // After reset the cs synchroniser holds presets; only trust cs high once the
  // chain has refilled, so a frame cut by reset is never picked up mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SETTLE_MAX) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end
      if ((r_settle == SETTLE_MAX) && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_lead_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_bit_cnt  <= '0;
      r_lead_cnt <= '0;
    end else begin
      if (w_lead_inc) begin
        r_lead_cnt <= r_lead_cnt + LEAD_CNT_W'(1);
      end
      if (w_shift_en && !w_word_done) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) begin
      r_shift <= w_shift_next;
    end
  end

  assign w_accept  = w_word_done && (!r_dout_valid || dout_ready);
  assign w_ovr_evt = w_word_done && r_dout_valid && !dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dout       <= w_shift_next;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      r_overrun   <= w_ovr_evt  | (r_overrun   & ~err_clr);
      r_frame_err <= w_ferr_evt | (r_frame_err & ~err_clr);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == LEAD) || (r_state == SHIFT);

endmodule
